// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use / RAW hazard detection and EX operand forwarding select.
// Define FORWARDING_EN for bypass selects; otherwise dependences stall until write-back.
module hazard_fwd_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       flush,
    output logic       stall,
    output logic       bubble,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
);
    typedef enum logic {RUN, STALL} state_t;
    state_t state, state_n;
    logic [4:0] ex_rd, mem_rd;
    logic ex_wr, ex_ld, mem_wr;
    logic ex_a, ex_b, mem_a, mem_b, haz, kill;
    logic [1:0] sel_a, sel_b;

    assign ex_a  = ex_wr  && ex_rd  == id_rs && id_rs != 5'd0;
    assign ex_b  = ex_wr  && ex_rd  == id_rt && id_rt != 5'd0;
    assign mem_a = mem_wr && mem_rd == id_rs && id_rs != 5'd0;
    assign mem_b = mem_wr && mem_rd == id_rt && id_rt != 5'd0;

`ifdef FORWARDING_EN
    assign haz   = ex_ld && (ex_a || ex_b);
    assign sel_a = ex_a ? 2'd1 : mem_a ? 2'd2 : 2'd0;
    assign sel_b = ex_b ? 2'd1 : mem_b ? 2'd2 : 2'd0;
`else
    // Without bypass, the only safe source is the register file after write-back.
    logic unused_ok;
    assign unused_ok = ex_ld;
    assign haz   = ex_a || ex_b || mem_a || mem_b;
    assign sel_a = 2'd0;
    assign sel_b = 2'd0;
`endif

    always_comb begin
        stall   = id_valid && !flush && haz;
        bubble  = stall;
        state_n = state;
        case (state)
            RUN:     state_n = stall ? STALL : RUN;
            STALL:   state_n = stall ? STALL : RUN;
            default: state_n = RUN;
        endcase
    end

    assign kill = stall || flush || !id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ex_rd     <= 5'd0;
            ex_wr     <= 1'b0;
            ex_ld     <= 1'b0;
            mem_rd    <= 5'd0;
            mem_wr    <= 1'b0;
            fwd_a_sel <= 2'd0;
            fwd_b_sel <= 2'd0;
        end else begin
            state     <= state_n;
            ex_rd     <= kill ? 5'd0 : id_rd;
            ex_wr     <= !kill && id_regwrite;
            ex_ld     <= !kill && id_memread;
            mem_rd    <= ex_rd;
            mem_wr    <= ex_wr;
            fwd_a_sel <= kill ? 2'd0 : sel_a;
            fwd_b_sel <= kill ? 2'd0 : sel_b;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed hazard/forwarding checks; covers FORWARDING_EN when defined.
module tb_hazard_fwd_ctrl;
    logic clk = 1'b0, rst, id_valid, id_regwrite, id_memread, flush;
    logic [4:0] id_rs, id_rt, id_rd;
    logic stall, bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall), .bubble(bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ins(input logic v, input int rs, input int rt, input int rd,
                       input logic rw, input logic mr, input logic fl);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
        id_regwrite = rw; id_memread = mr; flush = fl;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        ins(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        nop();
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_stall", {1'b0, stall}, 2'd0);
        chk("rst_bubble", {1'b0, bubble}, 2'd0);
        chk("rst_sel_a", fwd_a_sel, 2'd0);
        chk("rst_sel_b", fwd_b_sel, 2'd0);
        nop(); cyc(); cyc();
`ifdef FORWARDING_EN
        // add r3 ; sub r?,r3,r4 -> EX forward on A
        ins(1, 1, 2, 3, 1, 0, 0); chk("add_nostall", {1'b0, stall}, 2'd0); cyc();
        ins(1, 3, 4, 5, 1, 0, 0); chk("sub_nostall", {1'b0, stall}, 2'd0); cyc();
        chk("sub_sel_a", fwd_a_sel, 2'd1);
        chk("sub_sel_b", fwd_b_sel, 2'd0);
        // add r3 ; nop ; or using r3 as rt -> MEM forward on B
        ins(1, 1, 2, 3, 1, 0, 0); cyc();
        nop(); cyc();
        ins(1, 6, 3, 7, 1, 0, 0); chk("or_nostall", {1'b0, stall}, 2'd0); cyc();
        chk("or_sel_b", fwd_b_sel, 2'd2);
        chk("or_sel_a", fwd_a_sel, 2'd0);
        // two writers of r3 -> newest (EX) wins
        ins(1, 1, 2, 3, 1, 0, 0); cyc();
        ins(1, 1, 2, 3, 1, 0, 0); cyc();
        ins(1, 3, 3, 8, 1, 0, 0); cyc();
        chk("two_w_sel_a", fwd_a_sel, 2'd1);
        chk("two_w_sel_b", fwd_b_sel, 2'd1);
        nop(); cyc(); cyc();
        // lw r5 ; add using r5 -> one stall, then MEM forward
        ins(1, 1, 0, 5, 1, 1, 0); cyc();
        ins(1, 5, 9, 10, 1, 0, 0);
        chk("lu_stall", {1'b0, stall}, 2'd1);
        chk("lu_bubble", {1'b0, bubble}, 2'd1);
        cyc();
        chk("lu_bubble_sel_a", fwd_a_sel, 2'd0);
        chk("lu_stall2", {1'b0, stall}, 2'd0);
        cyc();
        chk("lu_sel_a", fwd_a_sel, 2'd2);
        nop(); cyc(); cyc();
        // r0 never matches
        ins(1, 1, 2, 0, 1, 1, 0); cyc();
        ins(1, 0, 0, 4, 1, 0, 0); chk("r0_stall", {1'b0, stall}, 2'd0); cyc();
        chk("r0_sel_a", fwd_a_sel, 2'd0);
        chk("r0_sel_b", fwd_b_sel, 2'd0);
        nop(); cyc(); cyc();
        // lw r5 + reader under flush -> flush wins
        ins(1, 1, 0, 5, 1, 1, 0); cyc();
        ins(1, 5, 5, 6, 1, 0, 1);
        chk("fl_stall", {1'b0, stall}, 2'd0);
        chk("fl_bubble", {1'b0, bubble}, 2'd0);
        cyc();
        chk("fl_sel_a", fwd_a_sel, 2'd0);
        ins(1, 6, 0, 7, 1, 0, 0); chk("fl_zero_ex", {1'b0, stall}, 2'd0); cyc();
        chk("fl_zero_sel", fwd_a_sel, 2'd0);
`else
        // add r3 ; reader of r3 -> two stall cycles, no forwarding
        ins(1, 1, 2, 3, 1, 0, 0); chk("add_nostall", {1'b0, stall}, 2'd0); cyc();
        ins(1, 3, 4, 5, 1, 0, 0);
        chk("ex_dep_stall1", {1'b0, stall}, 2'd1);
        chk("ex_dep_bubble1", {1'b0, bubble}, 2'd1);
        cyc();
        chk("ex_dep_stall2", {1'b0, stall}, 2'd1);
        chk("ex_dep_sel_a_st", fwd_a_sel, 2'd0);
        cyc();
        chk("ex_dep_release", {1'b0, stall}, 2'd0);
        cyc();
        chk("ex_dep_sel_a", fwd_a_sel, 2'd0);
        chk("ex_dep_sel_b", fwd_b_sel, 2'd0);
        nop(); cyc(); cyc();
        // MEM producer via rt -> one stall cycle
        ins(1, 1, 2, 7, 1, 0, 0); cyc();
        nop(); cyc();
        ins(1, 0, 7, 8, 1, 0, 0);
        chk("mem_dep_stall1", {1'b0, stall}, 2'd1);
        cyc();
        chk("mem_dep_release", {1'b0, stall}, 2'd0);
        nop(); cyc(); cyc();
        // non-writing producer and r0 never match
        ins(1, 1, 2, 9, 0, 0, 0); cyc();
        ins(1, 9, 9, 4, 1, 0, 0); chk("nowr_stall", {1'b0, stall}, 2'd0); cyc();
        nop(); cyc(); cyc();
        ins(1, 1, 2, 0, 1, 1, 0); cyc();
        ins(1, 0, 0, 4, 1, 0, 0); chk("r0_stall", {1'b0, stall}, 2'd0); cyc();
        nop(); cyc(); cyc();
        // flush beats a pending dependence; flushed slot holds no producer
        ins(1, 1, 2, 3, 1, 1, 0); cyc();
        ins(1, 3, 0, 6, 1, 0, 1);
        chk("fl_stall", {1'b0, stall}, 2'd0);
        chk("fl_bubble", {1'b0, bubble}, 2'd0);
        cyc();
        ins(1, 6, 0, 7, 1, 0, 0); chk("fl_zero_ex", {1'b0, stall}, 2'd0);
        ins(1, 3, 0, 7, 1, 0, 0); chk("fl_mem_dep", {1'b0, stall}, 2'd1);
        nop(); cyc(); cyc();
        // reset in the middle of a stall abandons it
        ins(1, 1, 2, 3, 1, 0, 0); cyc();
        ins(1, 3, 4, 5, 1, 0, 0);
        chk("rst_mid_pre", {1'b0, stall}, 2'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_mid_stall", {1'b0, stall}, 2'd0);
        chk("rst_mid_bubble", {1'b0, bubble}, 2'd0);
        chk("rst_mid_sel_a", fwd_a_sel, 2'd0);
        chk("rst_mid_sel_b", fwd_b_sel, 2'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
